// File: rtl/my_hack_pkg.sv
// rtl/my_hack_pkg.sv - Hack instruction field positions, ALU control struct and comp codes
package my_hack_pkg;

  localparam int I_BIT    = 15;
  localparam int A_BIT    = 12;
  localparam int COMP_LSB = 6;
  localparam int DEST_LSB = 3;
  localparam int JUMP_LSB = 0;

  // Member order matches instruction[11:6] so a plain cast decodes the comp field.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam logic [5:0] COMP_ZERO   = 6'b101010;
  localparam logic [5:0] COMP_D      = 6'b001100;
  localparam logic [5:0] COMP_A      = 6'b110000;
  localparam logic [5:0] COMP_NEG1   = 6'b111010;
  localparam logic [5:0] COMP_APLUS1 = 6'b110111;

  function automatic alu_ctrl_t get_alu_ctrl(input logic [15:0] instr);
    return alu_ctrl_t'(instr[COMP_LSB +: 6]);
  endfunction

endpackage

// File: rtl/my_alu.sv
// rtl/my_alu.sv - Hack ALU: optional zero/negate of each operand, add or and, optional negate of result
module my_alu
  import my_hack_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  alu_ctrl_t   ctrl,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x_z, x_n, y_z, y_n, res;

  always_comb begin
    x_z = ctrl.zx ? 16'h0000 : x;
    x_n = ctrl.nx ? ~x_z : x_z;
    y_z = ctrl.zy ? 16'h0000 : y;
    y_n = ctrl.ny ? ~y_z : y_z;
    res = ctrl.f ? (x_n + y_n) : (x_n & y_n);
    out = ctrl.no ? ~res : res;
    zr  = (out == 16'h0000);
    ng  = out[15];
  end

endmodule

// File: rtl/my_mux16.sv
// rtl/my_mux16.sv - 16-bit 2:1 multiplexer, out = sel ? b : a
module my_mux16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sel,
  output logic [15:0] out
);

  assign out = sel ? b : a;

endmodule

// File: rtl/my_pc.sv
// rtl/my_pc.sv - 15-bit program counter, priority reset > load > inc, wraps at 0x7FFF
module my_pc #(
  parameter logic [14:0] RESET_PC = 15'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        inc,
  input  logic [14:0] load_val,
  output logic [14:0] pc
);

  logic [14:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load)
      pc_d = load_val;
    else if (inc)
      pc_d = pc_q + 15'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/my_cpu.sv
// rtl/my_cpu.sv - single-cycle Hack CPU core: decode, A/D registers, jump logic, ALU control
module my_cpu
  import my_hack_pkg::*;
#(
  parameter logic [14:0] RESET_PC = 15'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic [15:0] inM,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [14:0] addressM,
  output logic [14:0] pc
);

  logic [15:0] a_d, a_q, d_d, d_q;
  logic [15:0] y_operand;
  logic        is_c, dest_a, dest_d, dest_m;
  logic        j_lt, j_eq, j_gt;
  logic        zero, neg, pos, jump;
  logic        alu_zr, alu_ng;
  logic        unused_bits;

  assign is_c   = instruction[I_BIT];
  assign dest_a = instruction[DEST_LSB + 2];
  assign dest_d = instruction[DEST_LSB + 1];
  assign dest_m = instruction[DEST_LSB];
  assign j_lt   = instruction[JUMP_LSB + 2];
  assign j_eq   = instruction[JUMP_LSB + 1];
  assign j_gt   = instruction[JUMP_LSB];

  my_mux16 u_y_mux (
    .a   (a_q),
    .b   (inM),
    .sel (instruction[A_BIT]),
    .out (y_operand)
  );

  my_alu u_alu (
    .x    (d_q),
    .y    (y_operand),
    .ctrl (get_alu_ctrl(instruction)),
    .out  (outM),
    .zr   (alu_zr),
    .ng   (alu_ng)
  );

  // Flags come from outM directly so jumps never depend on the ALU's own flag outputs.
  assign zero = (outM == 16'h0000);
  assign neg  = outM[15];
  assign pos  = ~zero & ~neg;
  assign jump = is_c & ((j_lt & neg) | (j_eq & zero) | (j_gt & pos));

  assign writeM   = is_c & dest_m & ~reset;
  assign addressM = a_q[14:0];

  always_comb begin
    a_d = a_q;
    d_d = d_q;
    if (!is_c)
      a_d = instruction;
    else if (dest_a)
      a_d = outM;
    if (is_c && dest_d)
      d_d = outM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= 16'h0000;
      d_q <= 16'h0000;
    end else begin
      a_q <= a_d;
      d_q <= d_d;
    end
  end

  // Jump target is the pre-update A, even when the same instruction also writes A.
  my_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (jump),
    .inc      (1'b1),
    .load_val (a_q[14:0]),
    .pc       (pc)
  );

  assign unused_bits = ^{alu_zr, alu_ng, instruction[14:13]};

endmodule
